// File: rtl/reg_file_mp_if.sv
// Register file bus: two write ports, PC count, bank swap, packed reads.
// Outputs: rdData, programCounter, bankSel, displayReg.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_READ   = 3
);
  localparam int IW = $clog2(NUM_REGS);

  logic                         countEnable;
  logic                         wrEnA;
  logic [IW-1:0]                wrAddrA;
  logic [DATA_WIDTH-1:0]        wrDataA;
  logic                         wrEnB;
  logic [IW-1:0]                wrAddrB;
  logic [DATA_WIDTH-1:0]        wrDataB;
  logic                         bankSwap;
  logic [NUM_READ*IW-1:0]       rdAddr;
  logic [NUM_READ*DATA_WIDTH-1:0] rdData;
  logic [DATA_WIDTH-1:0]        programCounter;
  logic                         bankSel;
  logic [2*DATA_WIDTH-1:0]      displayReg;

  modport master (
    output countEnable, wrEnA, wrAddrA, wrDataA,
    output wrEnB, wrAddrB, wrDataB, bankSwap, rdAddr,
    input  rdData, programCounter, bankSel, displayReg
  );

  modport slave (
    input  countEnable, wrEnA, wrAddrA, wrDataA,
    input  wrEnB, wrAddrB, wrDataB, bankSwap, rdAddr,
    output rdData, programCounter, bankSel, displayReg
  );
endinterface

// File: rtl/reg_file_mp.sv
// Banked multi-port register file: R0 zero, R1..N-2 banked, shared PC.
// Ports: clk, rst (async high), bus (slave); option REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_READ   = 3,
  parameter int PC_STEP    = 1
) (
  input logic         clk,
  input logic         rst,
  reg_file_mp_if.slave bus
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int NB = NUM_REGS - 2;
  localparam logic [IW-1:0] PCI = IW'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] bank0 [1:NB];
  logic [DATA_WIDTH-1:0] bank1 [1:NB];
  logic [DATA_WIDTH-1:0] pc;
  logic                  sel;

  logic [IW-1:0]                   a;
  logic [DATA_WIDTH-1:0]           v;
  logic [NUM_READ*DATA_WIDTH-1:0]  rd;

  // Port B is applied after port A so its write wins on a collision;
  // an explicit PC write overrides the increment the same way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= 1'b0;
      pc  <= '0;
      for (int i = 1; i <= NB; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      if (bus.bankSwap)
        sel <= ~sel;
      if (bus.countEnable)
        pc <= pc + DATA_WIDTH'(PC_STEP);
      if (bus.wrEnA && bus.wrAddrA == PCI)
        pc <= bus.wrDataA;
      if (bus.wrEnB && bus.wrAddrB == PCI)
        pc <= bus.wrDataB;
      for (int i = 1; i <= NB; i++) begin
        if (bus.wrEnA && bus.wrAddrA == IW'(i)) begin
          if (sel) bank1[i] <= bus.wrDataA;
          else     bank0[i] <= bus.wrDataA;
        end
        if (bus.wrEnB && bus.wrAddrB == IW'(i)) begin
          if (sel) bank1[i] <= bus.wrDataB;
          else     bank0[i] <= bus.wrDataB;
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    a  = '0;
    v  = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      a = bus.rdAddr[p*IW +: IW];
      v = '0;
      if (a == PCI)
        v = pc;
      for (int i = 1; i <= NB; i++) begin
        if (a == IW'(i))
          v = sel ? bank1[i] : bank0[i];
      end
`ifdef REG_FILE_MP_BYPASS_EN
      // Forward only real writes; held off in reset so reads stay 0.
      if (!rst && a != '0) begin
        if (bus.wrEnB && bus.wrAddrB == a)
          v = bus.wrDataB;
        else if (bus.wrEnA && bus.wrAddrA == a)
          v = bus.wrDataA;
      end
`endif
      rd[p*DATA_WIDTH +: DATA_WIDTH] = v;
    end
  end

  assign bus.rdData         = rd;
  assign bus.programCounter = pc;
  assign bus.bankSel        = sel;
  assign bus.displayReg     = sel ? {bank1[1], bank1[2]}
                                  : {bank0[1], bank0[2]};
endmodule
